// File: rtl/inst_mem_resp_pkg.sv
// Shared bus widths, polarity constants and FSM encoding for the instruction memory responder.
package inst_mem_resp_pkg;

  localparam int unsigned InstAddrBusW       = 32;
  localparam int unsigned InstBusW           = 32;
  localparam logic        RstEnable          = 1'b0;
  localparam logic [InstBusW-1:0] NopInst    = '0;
  localparam int unsigned InstMemLog2Default = 10;
  localparam int unsigned WaitCntW           = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [InstAddrBusW-1:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Word-addressed instruction storage: one write port, one registered read port (read-first).
module inst_mem_array #(
  parameter int unsigned AddrW = 10,
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [2**AddrW];
  logic [DataW-1:0] rdata_q;

  // Contents are deliberately never reset so a loaded program survives a core reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction fetch responder with flush kill and misalignment flag.
// Define INST_MEM_WAIT_EN to insert WAIT_CYCLES wait states per fetch (stall_o handshake).
module inst_mem_resp import inst_mem_resp_pkg::*; #(
  parameter int unsigned INST_MEM_LOG2 = InstMemLog2Default,
  parameter int unsigned WAIT_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [InstAddrBusW-1:0] addr,
  input  logic                    flush_i,
  input  logic                    we_i,
  input  logic [InstAddrBusW-1:0] waddr_i,
  input  logic [InstBusW-1:0]     wdata_i,
  output logic [InstBusW-1:0]     inst_o,
  output logic                    inst_valid_o,
  output logic                    addr_err_o,
  output logic                    stall_o
);

  localparam int unsigned IdxW = INST_MEM_LOG2;
  localparam logic [WaitCntW-1:0] WaitLast = WaitCntW'(WAIT_CYCLES - 1);

  logic [IdxW-1:0]     raddr_idx;
  logic [InstBusW-1:0] rdata;
  logic                valid_q;
  logic                err_q;
  logic                resp_live;
  logic                unused_bits;

`ifdef INST_MEM_WAIT_EN
  fetch_state_e            state_q;
  logic [WaitCntW-1:0]     cnt_q;
  logic [InstAddrBusW-1:0] addr_q;
  logic                    stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      stall_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        // RESP accepts a new request directly, so back-to-back fetches skip IDLE.
        StIdle, StResp: begin
          if (ce) begin
            state_q <= StWait;
            cnt_q   <= WaitLast;
            addr_q  <= addr;
            stall_q <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StWait: begin
          if (flush_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            stall_q <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= StResp;
            stall_q <= 1'b0;
            valid_q <= 1'b1;
            err_q   <= is_misaligned(addr_q);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  // The final WAIT edge reads the latched address so data lands in RESP.
  assign raddr_idx = (state_q == StWait) ? addr_q[IdxW+1:2] : addr[IdxW+1:2];
  assign stall_o   = stall_q;
`else
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= ce;
      err_q   <= ce & is_misaligned(addr);
    end
  end

  assign raddr_idx = addr[IdxW+1:2];
  assign stall_o   = 1'b0;
`endif

  inst_mem_array #(
    .AddrW (IdxW),
    .DataW (InstBusW)
  ) u_array (
    .clk_i   (clk),
    .we_i    (we_i),
    .waddr_i (waddr_i[IdxW+1:2]),
    .wdata_i (wdata_i),
    .raddr_i (raddr_idx),
    .rdata_o (rdata)
  );

  // A flush during the response cycle kills the response; it is not replayed.
  assign resp_live    = valid_q & ~flush_i;
  assign inst_valid_o = resp_live;
  assign addr_err_o   = resp_live & err_q;
  assign inst_o       = (resp_live && !err_q) ? rdata : NopInst;

  assign unused_bits = ^{waddr_i[InstAddrBusW-1:IdxW+2], waddr_i[1:0], WaitLast};

endmodule

// File: tb/tb_inst_mem_resp.sv
// Directed bench for inst_mem_resp; wait-state checks apply when INST_MEM_WAIT_EN is defined.
module tb_inst_mem_resp;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic        ce      = 1'b0;
  logic        flush_i = 1'b0;
  logic        we_i    = 1'b0;
  logic [31:0] addr    = '0;
  logic [31:0] waddr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        addr_err_o;
  logic        stall_o;

  int n_run  = 0;
  int n_fail = 0;

`ifdef INST_MEM_WAIT_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 1;
`endif

  always #5 clk = ~clk;

  inst_mem_resp #(
    .INST_MEM_LOG2 (10),
    .WAIT_CYCLES   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .addr         (addr),
    .flush_i      (flush_i),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .wdata_i      (wdata_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .addr_err_o   (addr_err_o),
    .stall_o      (stall_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    waddr_i = a;
    wdata_i = d;
    we_i    = 1'b1;
    tick();
    we_i    = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_run++; if (inst_o !== 32'h0) begin n_fail++; $display("FAIL rst_inst got %h want %h", inst_o, 32'h0); end
    n_run++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", inst_valid_o); end
    n_run++; if (addr_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", addr_err_o); end
    n_run++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", stall_o); end
    // Program load while held in reset; memory writes are not gated by reset.
    load(32'h0, 32'h1111_1111);
    load(32'h4, 32'h2222_2222);
    load(32'h8, 32'h3333_3333);
    load(32'h10, 32'h2401_0005);
    ce   = 1'b1;
    addr = 32'h10;
    tick();
    ce   = 1'b0;
    n_run++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_ce_valid got %b want 0", inst_valid_o); end
    #2 rst = 1'b1;
  endtask

  task automatic test_fetch();
    ce   = 1'b1;
    addr = 32'h10;
    tick();
    ce   = 1'b0;
    n_run++; if (inst_o !== 32'h2401_0005) begin n_fail++; $display("FAIL fetch_inst got %h want %h", inst_o, 32'h2401_0005); end
    n_run++; if (inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL fetch_valid got %b want 1", inst_valid_o); end
    n_run++; if (addr_err_o !== 1'b0) begin n_fail++; $display("FAIL fetch_err got %b want 0", addr_err_o); end
    tick();
    n_run++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", inst_valid_o); end
    n_run++; if (inst_o !== 32'h0) begin n_fail++; $display("FAIL idle_inst got %h want %h", inst_o, 32'h0); end
  endtask

  task automatic test_misaligned();
    ce   = 1'b1;
    addr = 32'h12;
    tick();
    ce   = 1'b0;
    n_run++; if (inst_o !== 32'h0) begin n_fail++; $display("FAIL misal_inst got %h want %h", inst_o, 32'h0); end
    n_run++; if (inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL misal_valid got %b want 1", inst_valid_o); end
    n_run++; if (addr_err_o !== 1'b1) begin n_fail++; $display("FAIL misal_err got %b want 1", addr_err_o); end
    tick();
    n_run++; if (addr_err_o !== 1'b0) begin n_fail++; $display("FAIL misal_clear got %b want 0", addr_err_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [3];
    exp_data[0] = 32'h1111_1111;
    exp_data[1] = 32'h2222_2222;
    exp_data[2] = 32'h3333_3333;
    ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 32'(i * 4);
      tick();
      n_run++; if (inst_valid_o !== 1'b1 || inst_o !== exp_data[i]) begin
        n_fail++; $display("FAIL b2b_%0d got v=%b %h want v=1 %h", i, inst_valid_o, inst_o, exp_data[i]);
      end
    end
    ce = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    ce   = 1'b1;
    addr = 32'h0;
    tick();
    n_run++; if (inst_o !== 32'h1111_1111) begin n_fail++; $display("FAIL flush_w0 got %h want %h", inst_o, 32'h1111_1111); end
    addr = 32'h4;
    tick();
    flush_i = 1'b1;
    #1;
    n_run++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_kill_valid got %b want 0", inst_valid_o); end
    n_run++; if (inst_o !== 32'h0) begin n_fail++; $display("FAIL flush_kill_inst got %h want %h", inst_o, 32'h0); end
    addr = 32'h8;
    tick();
    flush_i = 1'b0;
    ce      = 1'b0;
    #1;
    n_run++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h3333_3333) begin
      n_fail++; $display("FAIL flush_next got v=%b %h want v=1 %h", inst_valid_o, inst_o, 32'h3333_3333);
    end
    tick();
    n_run++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_after got %b want 0", inst_valid_o); end
  endtask

  task automatic test_wrap_and_rfw();
    ce   = 1'b1;
    addr = 32'h0000_1010;
    tick();
    n_run++; if (inst_o !== 32'h2401_0005) begin n_fail++; $display("FAIL wrap_inst got %h want %h", inst_o, 32'h2401_0005); end
    n_run++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL wrap_stall got %b want 0", stall_o); end
    addr    = 32'h10;
    we_i    = 1'b1;
    waddr_i = 32'h13;
    wdata_i = 32'hDEAD_BEEF;
    tick();
    we_i = 1'b0;
    n_run++; if (inst_o !== 32'h2401_0005) begin n_fail++; $display("FAIL rfw_old got %h want %h", inst_o, 32'h2401_0005); end
    tick();
    ce = 1'b0;
    n_run++; if (inst_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rfw_new got %h want %h", inst_o, 32'hDEAD_BEEF); end
    tick();
  endtask

  task automatic test_wait_states();
    ce   = 1'b1;
    addr = 32'h10;
    tick();
    addr = 32'h0;
    n_run++; if (stall_o !== 1'b1 || inst_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL wait_c1 got s=%b v=%b want s=1 v=0", stall_o, inst_valid_o);
    end
    tick();
    ce = 1'b0;
    n_run++; if (stall_o !== 1'b1 || inst_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL wait_c2 got s=%b v=%b want s=1 v=0", stall_o, inst_valid_o);
    end
    tick();
    n_run++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h2401_0005) begin
      n_fail++; $display("FAIL wait_resp got v=%b %h want v=1 %h", inst_valid_o, inst_o, 32'h2401_0005);
    end
    n_run++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL wait_resp_stall got %b want 0", stall_o); end
    tick();
    n_run++; if (inst_valid_o !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL wait_no_queue got v=%b s=%b want v=0 s=0", inst_valid_o, stall_o);
    end
    ce   = 1'b1;
    addr = 32'h10;
    tick();
    ce      = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_run++; if (stall_o !== 1'b0 || inst_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL wait_flush got s=%b v=%b want s=0 v=0", stall_o, inst_valid_o);
    end
    tick();
    n_run++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL wait_flush_resp got %b want 0", inst_valid_o); end
  endtask

  task automatic test_async_reset();
    ce   = 1'b1;
    addr = 32'h10;
    tick();
    ce = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_run++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0) begin
      n_fail++; $display("FAIL arst_out got v=%b %h want v=0 0", inst_valid_o, inst_o);
    end
    n_run++; if (stall_o !== 1'b0 || addr_err_o !== 1'b0) begin
      n_fail++; $display("FAIL arst_flags got s=%b e=%b want 0 0", stall_o, addr_err_o);
    end
    #1 rst = 1'b1;
    ce   = 1'b1;
    addr = 32'h4;
    tick();
    ce = 1'b0;
    for (int i = 1; i < Lat; i++) tick();
    n_run++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h2222_2222) begin
      n_fail++; $display("FAIL arst_first got v=%b %h want v=1 %h", inst_valid_o, inst_o, 32'h2222_2222);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
`ifdef INST_MEM_WAIT_EN
    test_wait_states();
`else
    test_fetch();
    test_misaligned();
    test_back_to_back();
    test_flush();
    test_wrap_and_rfw();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
